// File: rtl/tlc_pkg.sv
// Shared types and constants for the traffic light controller.
// States, lamp codes, selector codes, defaults and interval helper.
package tlc_pkg;

  localparam int CNT_W = 5;
  localparam int TV_W  = 4;

  typedef logic [2:0] state_t;

  localparam state_t S_MAIN_GREEN  = 3'd0;
  localparam state_t S_MAIN_EXT    = 3'd1;
  localparam state_t S_MAIN_YELLOW = 3'd2;
  localparam state_t S_WALK        = 3'd3;
  localparam state_t S_SIDE_GREEN  = 3'd4;
  localparam state_t S_SIDE_YELLOW = 3'd5;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;
  localparam logic [1:0] SEL_NOP  = 2'b11;

  localparam int DEF_T_BASE = 6;
  localparam int DEF_T_EXT  = 3;
  localparam int DEF_T_YEL  = 2;

  // Interval, in ticks, that a state runs for.
  function automatic logic [CNT_W-1:0] interval_of(
    input state_t          s,
    input logic [TV_W-1:0] tb,
    input logic [TV_W-1:0] te,
    input logic [TV_W-1:0] ty
  );
    case (s)
      S_MAIN_GREEN: return {tb, 1'b0};
      S_MAIN_EXT:   return {1'b0, te};
      S_WALK:       return {1'b0, te};
      S_SIDE_GREEN: return {1'b0, tb};
      default:      return {1'b0, ty};
    endcase
  endfunction

endpackage

// File: rtl/tlc_interval_timer.sv
// Tick divider plus interval down-counter; load restarts both.
// WALK_FLASH_EN adds a flash_off output for the last half tick.
module tlc_interval_timer
  import tlc_pkg::*;
#(
  parameter int              TICK_CYCLES = 100000000,
  parameter logic [CNT_W-1:0] RST_N      = 5'd12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] n,
`ifdef WALK_FLASH_EN
  output logic             flash_off,
`endif
  output logic             expired
);

  localparam int DW =
    (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(TICK_CYCLES - 1);

  logic [DW-1:0]    div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_end;

  assign tick_end = (div_q == DIV_LAST);
  assign expired  = tick_end && (cnt_q == CNT_W'(1));

`ifdef WALK_FLASH_EN
  localparam logic [DW-1:0] DIV_HALF =
    DW'(TICK_CYCLES / 2);
  assign flash_off = (cnt_q == CNT_W'(1)) &&
                     (div_q >= DIV_HALF);
`endif

  // Advance divider; count down one interval unit per tick.
  always_comb begin
    div_d = tick_end ? '0 : div_q + 1'b1;
    cnt_d = tick_end ? cnt_q - 1'b1 : cnt_q;
    if (load) begin
      div_d = '0;
      cnt_d = n;
    end
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= RST_N;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Main traffic light sequencer with reprogrammable intervals.
// WALK_FLASH_EN flashes the walk lamp during the final WALK tick.
module traffic_light_fsm
  import tlc_pkg::*;
#(
  parameter int TICK_CYCLES = 100000000,
  parameter int T_BASE_DEF  = DEF_T_BASE,
  parameter int T_EXT_DEF   = DEF_T_EXT,
  parameter int T_YEL_DEF   = DEF_T_YEL
) (
  input  logic       clk,
  input  logic       Reset_n,
  input  logic       Reset_Sync,
  input  logic       Sensor_Sync,
  input  logic       WR_Sync,
  input  logic       Prog_Sync,
  input  logic [1:0] Time_Param_Selector,
  input  logic [3:0] Time_Value,
  output logic [2:0] Main_Light,
  output logic [2:0] Side_Light,
  output logic       Walk_Light
);

  localparam logic [TV_W-1:0] TB_RST = TV_W'(T_BASE_DEF);
  localparam logic [TV_W-1:0] TE_RST = TV_W'(T_EXT_DEF);
  localparam logic [TV_W-1:0] TY_RST = TV_W'(T_YEL_DEF);
  localparam logic [CNT_W-1:0] CNT_RST =
    CNT_W'(2 * T_BASE_DEF);

  state_t          state_q, state_d;
  logic [TV_W-1:0] t_base_q, t_base_d;
  logic [TV_W-1:0] t_ext_q, t_ext_d;
  logic [TV_W-1:0] t_yel_q, t_yel_d;
  logic            walk_pending_q, walk_pending_d;

  logic             prog_ok;
  logic             restart;
  logic             expired;
  logic             enter_walk;
  logic [CNT_W-1:0] load_n;

  assign prog_ok = Prog_Sync &&
                   (Time_Param_Selector != SEL_NOP) &&
                   (Time_Value != '0);

  // Next state and interval registers, by priority.
  always_comb begin
    state_d  = state_q;
    t_base_d = t_base_q;
    t_ext_d  = t_ext_q;
    t_yel_d  = t_yel_q;
    restart  = 1'b0;
    if (Reset_Sync) begin
      state_d  = S_MAIN_GREEN;
      t_base_d = TB_RST;
      t_ext_d  = TE_RST;
      t_yel_d  = TY_RST;
      restart  = 1'b1;
    end else if (prog_ok) begin
      unique case (1'b1)
        Time_Param_Selector == SEL_BASE:
          t_base_d = Time_Value;
        Time_Param_Selector == SEL_EXT:
          t_ext_d = Time_Value;
        Time_Param_Selector == SEL_YEL:
          t_yel_d = Time_Value;
        default: ;
      endcase
      state_d = S_MAIN_GREEN;
      restart = 1'b1;
    end else if (expired) begin
      case (state_q)
        S_MAIN_GREEN:
          state_d = Sensor_Sync ? S_MAIN_EXT
                                : S_MAIN_YELLOW;
        S_MAIN_EXT:
          state_d = S_MAIN_YELLOW;
        S_MAIN_YELLOW:
          state_d = walk_pending_q ? S_WALK
                                   : S_SIDE_GREEN;
        S_WALK:
          state_d = S_SIDE_GREEN;
        S_SIDE_GREEN:
          state_d = S_SIDE_YELLOW;
        default:
          state_d = S_MAIN_GREEN;
      endcase
    end
  end

  assign enter_walk = (state_d == S_WALK) &&
                      (state_q != S_WALK);

  // Walk request latch; a new request beats the entry clear.
  always_comb begin
    walk_pending_d = (walk_pending_q && !enter_walk) ||
                     WR_Sync;
    if (Reset_Sync) walk_pending_d = 1'b0;
  end

  assign load_n = interval_of(state_d, t_base_d,
                              t_ext_d, t_yel_d);

`ifdef WALK_FLASH_EN
  logic flash_off;
`endif

  tlc_interval_timer #(
    .TICK_CYCLES (TICK_CYCLES),
    .RST_N       (CNT_RST)
  ) u_timer (
    .clk       (clk),
    .rst_n     (Reset_n),
    .load      (restart || expired),
    .n         (load_n),
`ifdef WALK_FLASH_EN
    .flash_off (flash_off),
`endif
    .expired   (expired)
  );

  // Sequencer state and programmable intervals.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= S_MAIN_GREEN;
      t_base_q       <= TB_RST;
      t_ext_q        <= TE_RST;
      t_yel_q        <= TY_RST;
      walk_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      t_base_q       <= t_base_d;
      t_ext_q        <= t_ext_d;
      t_yel_q        <= t_yel_d;
      walk_pending_q <= walk_pending_d;
    end
  end

  // Lamp decode; unknown codes fall back to main green.
  always_comb begin
    Main_Light = LAMP_GRN;
    Side_Light = LAMP_RED;
    case (state_q)
      S_MAIN_YELLOW: Main_Light = LAMP_YEL;
      S_WALK:        Main_Light = LAMP_RED;
      S_SIDE_GREEN: begin
        Main_Light = LAMP_RED;
        Side_Light = LAMP_GRN;
      end
      S_SIDE_YELLOW: begin
        Main_Light = LAMP_RED;
        Side_Light = LAMP_YEL;
      end
      default: ;
    endcase
  end

`ifdef WALK_FLASH_EN
  assign Walk_Light = (state_q == S_WALK) && !flash_off;
`else
  assign Walk_Light = (state_q == S_WALK);
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm (TICK_CYCLES=4).
// Directed phase timing plus randomized run against a phase model.
module tb_traffic_light_fsm;

  localparam int TICK = 4;
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Reset_Sync = 1'b0;
  logic       Sensor_Sync = 1'b0;
  logic       WR_Sync = 1'b0;
  logic       Prog_Sync = 1'b0;
  logic [1:0] sel = 2'b00;
  logic [3:0] val = 4'd0;
  logic [2:0] Main_Light, Side_Light;
  logic       Walk_Light;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_light_fsm #(.TICK_CYCLES(TICK)) dut (
    .clk                 (clk),
    .Reset_n             (Reset_n),
    .Reset_Sync          (Reset_Sync),
    .Sensor_Sync         (Sensor_Sync),
    .WR_Sync             (WR_Sync),
    .Prog_Sync           (Prog_Sync),
    .Time_Param_Selector (sel),
    .Time_Value          (val),
    .Main_Light          (Main_Light),
    .Side_Light          (Side_Light),
    .Walk_Light          (Walk_Light)
  );

  always #5 clk = ~clk;

  // Phase model: current phase and cycles left in it.
  typedef enum int {P_MG, P_ME, P_MY, P_WK, P_SG, P_SY} phase_e;
  phase_e m_ph;
  int     m_rem, m_tb, m_te, m_ty;
  bit     m_pend;

  function automatic int dur(phase_e p);
    case (p)
      P_MG:    return 2 * m_tb * TICK;
      P_ME:    return m_te * TICK;
      P_WK:    return m_te * TICK;
      P_SG:    return m_tb * TICK;
      default: return m_ty * TICK;
    endcase
  endfunction

  function automatic logic [6:0] expect_out();
    logic w;
`ifdef WALK_FLASH_EN
    w = (m_rem > TICK - TICK / 2);
`else
    w = 1'b1;
`endif
    case (m_ph)
      P_MG, P_ME: return {G, R, 1'b0};
      P_MY:       return {Y, R, 1'b0};
      P_WK:       return {R, R, w};
      P_SG:       return {R, G, 1'b0};
      default:    return {R, Y, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_tb = 6; m_te = 3; m_ty = 2;
    m_ph = P_MG; m_rem = dur(P_MG);
    m_pend = 0;
  endtask

  task automatic model_step();
    phase_e nx;
    if (Reset_Sync) begin
      model_reset();
    end else if (Prog_Sync && sel != 2'b11 && val != 0) begin
      if (sel == 2'b00) m_tb = int'(val);
      if (sel == 2'b01) m_te = int'(val);
      if (sel == 2'b10) m_ty = int'(val);
      m_ph = P_MG; m_rem = dur(P_MG);
      m_pend = m_pend | WR_Sync;
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        case (m_ph)
          P_MG:    nx = Sensor_Sync ? P_ME : P_MY;
          P_ME:    nx = P_MY;
          P_MY:    nx = m_pend ? P_WK : P_SG;
          P_WK:    nx = P_SG;
          P_SG:    nx = P_SY;
          default: nx = P_MG;
        endcase
        m_ph = nx; m_rem = dur(nx);
        if (nx == P_WK) m_pend = 0;
      end
      m_pend = m_pend | WR_Sync;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic arst();
    Reset_n = 1'b0;
    #1;
    model_reset();
  endtask

  // Count observations spent on the current main/side lamps.
  task automatic measure(output int n);
    logic [5:0] cur;
    cur = {Main_Light, Side_Light};
    n = 0;
    do begin
      n++;
      tick();
    end while ({Main_Light, Side_Light} == cur && n < 300);
  endtask

  task automatic test_reset();
    arst();
    n_cmp++;
    if ({Main_Light, Side_Light, Walk_Light} !== {G, R, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_lights: got %b want %b",
        {Main_Light, Side_Light, Walk_Light}, {G, R, 1'b0});
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_default_cycle();
    logic [2:0] em [4] = '{G, Y, R, R};
    logic [2:0] es [4] = '{R, R, G, Y};
    int         ec [4] = '{48, 8, 24, 8};
    int n;
    arst(); Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({Main_Light, Side_Light, Walk_Light} !== {em[i], es[i], 1'b0}) begin
        n_bad++;
        $display("FAIL default_lights[%0d]: got %b want %b", i,
          {Main_Light, Side_Light, Walk_Light}, {em[i], es[i], 1'b0});
      end
      measure(n);
      n_cmp++;
      if (n != ec[i]) begin
        n_bad++;
        $display("FAIL default_len[%0d]: got %0d want %0d", i, n, ec[i]);
      end
    end
    n_cmp++;
    if (Main_Light !== G) begin
      n_bad++;
      $display("FAIL default_wrap: main %b want %b", Main_Light, G);
    end
  endtask

  task automatic test_sensor();
    int n;
    arst(); Reset_n = 1'b1;
    Sensor_Sync = 1'b1;
    measure(n);
    Sensor_Sync = 1'b0;
    n_cmp++;
    if (n != 60) begin
      n_bad++;
      $display("FAIL sensor_ext: main G %0d want 60", n);
    end
    measure(n); measure(n); measure(n);
    measure(n);
    n_cmp++;
    if (n != 48) begin
      n_bad++;
      $display("FAIL sensor_none: main G %0d want 48", n);
    end
  endtask

  task automatic test_walk();
    int n;
    logic w;
    arst(); Reset_n = 1'b1;
    measure(n); measure(n);
    WR_Sync = 1'b1; tick(); WR_Sync = 1'b0;
    measure(n);
    n_cmp++;
    if (n != 23) begin
      n_bad++;
      $display("FAIL walk_sg_rest: got %0d want 23", n);
    end
    measure(n); measure(n);
    measure(n);
    n_cmp++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL walk_my: got %0d want 8", n);
    end
    for (int i = 0; i < 12; i++) begin
`ifdef WALK_FLASH_EN
      w = (i < 10);
`else
      w = 1'b1;
`endif
      n_cmp++;
      if ({Main_Light, Side_Light, Walk_Light} !== {R, R, w}) begin
        n_bad++;
        $display("FAIL walk_cyc[%0d]: got %b want %b", i,
          {Main_Light, Side_Light, Walk_Light}, {R, R, w});
      end
      tick();
    end
    n_cmp++;
    if (Side_Light !== G) begin
      n_bad++;
      $display("FAIL walk_to_sg: side %b want %b", Side_Light, G);
    end
    measure(n); measure(n); measure(n); measure(n);
    n_cmp++;
    if ({Main_Light, Side_Light, Walk_Light} !== {R, G, 1'b0}) begin
      n_bad++;
      $display("FAIL walk_once: got %b want %b",
        {Main_Light, Side_Light, Walk_Light}, {R, G, 1'b0});
    end
  endtask

  task automatic test_prog();
    int n;
    arst(); Reset_n = 1'b1;
    measure(n); measure(n);
    repeat (5) tick();
    sel = 2'b00; val = 4'd2; Prog_Sync = 1'b1;
    tick();
    Prog_Sync = 1'b0;
    n_cmp++;
    if (Main_Light !== G || Side_Light !== R) begin
      n_bad++;
      $display("FAIL prog_restart: got %b/%b want %b/%b",
        Main_Light, Side_Light, G, R);
    end
    measure(n);
    n_cmp++;
    if (n != 16) begin
      n_bad++;
      $display("FAIL prog_mg: got %0d want 16", n);
    end
    measure(n);
    measure(n);
    n_cmp++;
    if (n != 8) begin
      n_bad++;
      $display("FAIL prog_sg: got %0d want 8", n);
    end
    measure(n); measure(n); measure(n);
    val = 4'd0; Prog_Sync = 1'b1; tick();
    sel = 2'b11; val = 4'd5; tick();
    Prog_Sync = 1'b0; val = 4'd0; sel = 2'b00;
    n_cmp++;
    if (Side_Light !== G) begin
      n_bad++;
      $display("FAIL prog_ignored: side %b want %b", Side_Light, G);
    end
    measure(n);
    n_cmp++;
    if (n != 6) begin
      n_bad++;
      $display("FAIL prog_ignored_len: got %0d want 6", n);
    end
  endtask

  task automatic test_async_reset();
    int n;
    arst(); Reset_n = 1'b1;
    WR_Sync = 1'b1; tick(); WR_Sync = 1'b0;
    measure(n); measure(n);
    repeat (5) tick();
    n_cmp++;
    if (Walk_Light !== 1'b1 || Main_Light !== R) begin
      n_bad++;
      $display("FAIL arst_in_walk: walk %b main %b want 1/%b",
        Walk_Light, Main_Light, R);
    end
    arst();
    n_cmp++;
    if ({Main_Light, Side_Light, Walk_Light} !== {G, R, 1'b0}) begin
      n_bad++;
      $display("FAIL arst_async: got %b want %b",
        {Main_Light, Side_Light, Walk_Light}, {G, R, 1'b0});
    end
    Reset_n = 1'b1;
    measure(n); measure(n);
    n_cmp++;
    if (Side_Light !== G || Walk_Light !== 1'b0) begin
      n_bad++;
      $display("FAIL arst_pend_clr: side %b walk %b want %b/0",
        Side_Light, Walk_Light, G);
    end
  endtask

  task automatic test_reset_sync();
    int n;
    arst(); Reset_n = 1'b1;
    WR_Sync = 1'b1; tick(); WR_Sync = 1'b0;
    measure(n);
    repeat (3) tick();
    Reset_Sync = 1'b1; tick(); Reset_Sync = 1'b0;
    n_cmp++;
    if ({Main_Light, Side_Light, Walk_Light} !== {G, R, 1'b0}) begin
      n_bad++;
      $display("FAIL rsync_lights: got %b want %b",
        {Main_Light, Side_Light, Walk_Light}, {G, R, 1'b0});
    end
    measure(n);
    n_cmp++;
    if (n != 48) begin
      n_bad++;
      $display("FAIL rsync_mg: got %0d want 48", n);
    end
    measure(n);
    n_cmp++;
    if (Side_Light !== G) begin
      n_bad++;
      $display("FAIL rsync_pend_clr: side %b want %b", Side_Light, G);
    end
  endtask

  task automatic test_random();
    logic [6:0] exp;
    int shown = 0;
    arst(); Reset_n = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      Sensor_Sync = 1'($urandom_range(0, 1));
      WR_Sync     = ($urandom_range(0, 29) == 0);
      Prog_Sync   = ($urandom_range(0, 149) == 0);
      Reset_Sync  = ($urandom_range(0, 699) == 0);
      sel         = 2'($urandom_range(0, 3));
      val         = 4'($urandom_range(0, 4));
      tick();
      exp = expect_out();
      n_cmp++;
      if ({Main_Light, Side_Light, Walk_Light} !== exp) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random[%0d]: got %b want %b", c,
            {Main_Light, Side_Light, Walk_Light}, exp);
        end
      end
      n_cmp++;
      if (!$onehot(Main_Light) || !$onehot(Side_Light) ||
          (Main_Light != R && Side_Light != R)) begin
        n_bad++;
        if (shown < 10) begin
          shown++;
          $display("FAIL lamp_safety[%0d]: main %b side %b", c,
            Main_Light, Side_Light);
        end
      end
    end
    Sensor_Sync = 1'b0; WR_Sync = 1'b0; Prog_Sync = 1'b0;
    Reset_Sync = 1'b0; sel = 2'b00; val = 4'd0;
  endtask

  initial begin
    #2;
    test_reset();
    test_default_cycle();
    test_sensor();
    test_walk();
    test_prog();
    test_async_reset();
    test_reset_sync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Main sequencer of the traffic light controller; consumes the synchronized outputs of the Synchronizer (Prog_Sync, WR_Sync, Sensor_Sync, Reset_Sync).
- Drives main-street and side-street lamps and the pedestrian walk lamp through a fixed phase cycle, timed by a programmable-interval timer.
- Reprogram path loads new interval values at run time.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per timing tick (1 s at 100 MHz); bench uses 4.
- T_BASE_DEF, 6, reset value of base interval, in ticks.
- T_EXT_DEF, 3, reset value of extension interval, in ticks.
- T_YEL_DEF, 2, reset value of yellow interval, in ticks.

Ports:
- clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous active-low reset
- Reset_Sync  in  1  synchronous soft reset, active-high, synchronized
- Sensor_Sync  in  1  side-street vehicle sensor, synchronized
- WR_Sync  in  1  walk request, synchronized
- Prog_Sync  in  1  reprogram strobe, synchronized
- Time_Param_Selector  in  2  00=t_base, 01=t_ext, 10=t_yel, 11=no-op
- Time_Value  in  4  new interval in ticks, 1..15
- Main_Light  out  3  {R,Y,G} one-hot
- Side_Light  out  3  {R,Y,G} one-hot
- Walk_Light  out  1  pedestrian walk lamp

Behaviour:
- Reset (Reset_n low, async): state=MAIN_GREEN; Main_Light=001; Side_Light=100; Walk_Light=0; walk_pending=0; t_base/t_ext/t_yel=defaults; timer loaded with 2*t_base and divider cleared.
- Reset_Sync high at a clk edge: same effect as Reset_n, applied synchronously.
- Timer: on state entry, divider clears and interval counter (5 bits) loads N. Each state lasts exactly N*TICK_CYCLES clk cycles; expiry is a 1-cycle internal pulse; the next state's lights appear on the following edge.
- States, with lights as main/side/walk and interval:
  - MAIN_GREEN: G/R/0, 2*t_base. On expiry, go to MAIN_EXT if Sensor_Sync=1, otherwise MAIN_YELLOW.
  - MAIN_EXT: G/R/0, t_ext. Then MAIN_YELLOW. Taken at most once per cycle; Sensor_Sync is not re-sampled.
  - MAIN_YELLOW: Y/R/0, t_yel. Then WALK if walk_pending, otherwise SIDE_GREEN.
  - WALK: R/R/1, t_ext. Then SIDE_GREEN.
  - SIDE_GREEN: R/G/0, t_base. Then SIDE_YELLOW.
  - SIDE_YELLOW: R/Y/0, t_yel. Then MAIN_GREEN.
- walk_pending: set by WR_Sync=1 in any cycle; cleared on entry to WALK.
  - A request arriving during WALK is held for the next cycle.
  - Set and clear in the same cycle: set wins.
- Prog_Sync=1 with selector 00..10 and Time_Value!=0: write the selected register, then restart at MAIN_GREEN with new values. walk_pending is preserved.
- Prog_Sync with Time_Value=0 or selector 11: ignored, no restart.
- Priority: Reset_n > Reset_Sync > Prog_Sync > timer expiry.
- Prog_Sync held high for several cycles restarts on every cycle it is high; the bench pulses it for one cycle.
- Exactly one lamp is lit per street at all times. Main and side are never both non-red.

Optional Feature:
- Macro: WALK_FLASH_EN.
- Defined: during the final tick of WALK, Walk_Light is 1 for the first TICK_CYCLES/2 cycles and 0 for the rest (flash warning).
- Undefined: Walk_Light is steady 1 for all of WALK.

Decomposition:
- Package tlc_pkg: state enum (6 states), lamp encodings RED=100/YEL=010/GRN=001, selector codes, default interval constants, counter width.
- Sub-module tlc_interval_timer: tick divider plus 5-bit down-counter, with load/N inputs and an expired output.

Test Plan (TICK_CYCLES=4, defaults):
- Reset release, no inputs: main G for 48 cycles, Y for 8; side G for 24, Y for 8; then back to main G. Walk_Light stays 0.
- Sensor_Sync=1 at MAIN_GREEN expiry: main G lasts 48+12=60 cycles before Y. Sensor_Sync=0: 48 cycles.
- WR_Sync 1-cycle pulse during SIDE_GREEN: next cycle runs main Y (8), then WALK all-red with Walk_Light=1 for 12 cycles, then side G. Following cycle has no WALK.
- Prog_Sync, selector=00, value=2, mid SIDE_GREEN: next edge main G. Main G lasts 16 cycles; side G lasts 8. Same with value=0: no change, no restart.
- Reset_n asserted mid-WALK: outputs go to 001/100/0 without a clock edge, and walk_pending clears. Reset_Sync mid-MAIN_YELLOW gives the same result at the next edge.
- WALK_FLASH_EN defined: during WALK, Walk_Light=1 for cycles 0-9, 0 for cycles 10-11.
